// File: rtl/param_sync_counter.sv
// Parametrised synchronous up/down counter with load, wrap/saturate boundaries,
// a combinational terminal-count strobe and a sticky boundary-crossing flag.
module param_sync_counter #(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int              SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_n,
    output logic             tc,
    output logic             ovf
);

    // 64-bit bound so that MODULUS = 2^32 can still be expressed and checked
    localparam longint unsigned MAX_MODULUS = 64'd1 << WIDTH;
    localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MODULUS - 64'd1);
    localparam bit               HOLD_AT_BOUNDARY = (SATURATE != 0);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("param_sync_counter: WIDTH must be in 2..32");
        end
        if (MODULUS < 2 || MODULUS > MAX_MODULUS) begin : g_bad_modulus
            $error("param_sync_counter: MODULUS must be in 2..2^WIDTH");
        end
    endgenerate

    logic             at_max;
    logic             at_min;
    logic [WIDTH-1:0] din_clamped;
    logic [WIDTH-1:0] count_next;
    logic             ovf_set;

    assign at_max      = (count == MAX_VAL);
    assign at_min      = (count == '0);
    assign din_clamped = (din > MAX_VAL) ? MAX_VAL : din;

    // Next count and boundary detection; rst is folded in at the register
    always_comb begin
        count_next = count;
        ovf_set    = 1'b0;
        if (load) begin
            count_next = din_clamped;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
                    ovf_set    = 1'b1;
                    count_next = HOLD_AT_BOUNDARY ? count : '0;
                end else begin
                    count_next = count + WIDTH'(1);
                end
            end else begin
                if (at_min) begin
                    ovf_set    = 1'b1;
                    count_next = HOLD_AT_BOUNDARY ? count : MAX_VAL;
                end else begin
                    count_next = count - WIDTH'(1);
                end
            end
        end
    end

    // A boundary event on the same edge as clr_ovf leaves the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            ovf   <= ovf_set | (ovf & ~clr_ovf);
        end
    end

    assign count_n = ~count;
    assign tc      = en & ~load & ~rst & (up ? at_max : at_min);

endmodule

// File: tb/tb_param_sync_counter.sv
// Self-checking bench: four counter configurations share one stimulus stream and
// are compared every cycle against an arithmetic model, plus pinned literal values.
module tb_param_sync_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, load, clr_ovf;
    logic [7:0] din;

    logic [3:0] c0, cn0, c1, cn1, c2, cn2;
    logic [7:0] c3, cn3;
    logic       tc0, tc1, tc2, tc3, ovf0, ovf1, ovf2, ovf3;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    int wid [4] = '{4, 4, 4, 8};
    int md  [4] = '{16, 10, 10, 256};
    int sat [4] = '{0, 0, 1, 0};
    int mc  [4] = '{0, 0, 0, 0};
    bit mo  [4] = '{0, 0, 0, 0};

    int act_c [4];
    int act_cn[4];
    int act_tc[4];
    int act_ov[4];

    always #5 clk = ~clk;

    param_sync_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din[3:0]),
        .clr_ovf(clr_ovf), .count(c0), .count_n(cn0), .tc(tc0), .ovf(ovf0));
    param_sync_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din[3:0]),
        .clr_ovf(clr_ovf), .count(c1), .count_n(cn1), .tc(tc1), .ovf(ovf1));
    param_sync_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din[3:0]),
        .clr_ovf(clr_ovf), .count(c2), .count_n(cn2), .tc(tc2), .ovf(ovf2));
    param_sync_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(0)) dut3 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
        .clr_ovf(clr_ovf), .count(c3), .count_n(cn3), .tc(tc3), .ovf(ovf3));

    always_comb begin
        act_c[0] = int'(c0);  act_cn[0] = int'(cn0); act_tc[0] = int'(tc0); act_ov[0] = int'(ovf0);
        act_c[1] = int'(c1);  act_cn[1] = int'(cn1); act_tc[1] = int'(tc1); act_ov[1] = int'(ovf1);
        act_c[2] = int'(c2);  act_cn[2] = int'(cn2); act_tc[2] = int'(tc2); act_ov[2] = int'(ovf2);
        act_c[3] = int'(c3);  act_cn[3] = int'(cn3); act_tc[3] = int'(tc3); act_ov[3] = int'(ovf3);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock edge with the given inputs; returns just after the edge
    task automatic applyStimulus(input bit r, input bit e, input bit u, input bit l,
                                 input int d, input bit c);
        rst = r; en = e; up = u; load = l; din = 8'(d); clr_ovf = c;
        @(posedge clk);
        #1;
    endtask

    // Model: the count is an integer in 0..md-1; a step leaving that range is a boundary
    always @(posedge clk) begin : model
        int nxt;
        int d;
        bit bnd;
        for (int i = 0; i < 4; i++) begin
            bnd = 1'b0;
            if (rst) begin
                mc[i] = 0;
                mo[i] = 1'b0;
            end else begin
                if (load) begin
                    d = int'(din) % (1 << wid[i]);
                    mc[i] = (d > md[i] - 1) ? md[i] - 1 : d;
                end else if (en) begin
                    nxt = mc[i] + (up ? 1 : -1);
                    if (nxt < 0 || nxt >= md[i]) begin
                        bnd = 1'b1;
                        if (sat[i] != 0) nxt = mc[i];
                        else             nxt = up ? 0 : md[i] - 1;
                    end
                    mc[i] = nxt;
                end
                mo[i] = bnd | (mo[i] & ~clr_ovf);
            end
        end
    end

    always @(negedge clk) begin : compare
        int exp_tc;
        if (checking) begin
            for (int i = 0; i < 4; i++) begin
                exp_tc = (en && !load && !rst &&
                          (up ? (mc[i] == md[i] - 1) : (mc[i] == 0))) ? 1 : 0;
                checkOutput($sformatf("dut%0d count", i), act_c[i], mc[i]);
                checkOutput($sformatf("dut%0d count_n", i), act_cn[i],
                            (~mc[i]) & ((1 << wid[i]) - 1));
                checkOutput($sformatf("dut%0d tc", i), act_tc[i], exp_tc);
                checkOutput($sformatf("dut%0d ovf", i), act_ov[i], int'(mo[i]));
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; din = '0; clr_ovf = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checking = 1'b1;
        checkOutput("reset count", act_c[0], 0);
        checkOutput("reset count_n", act_cn[0], 15);
        checkOutput("reset ovf", act_ov[3], 0);

        // Free-running up count
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(0, 1, 1, 0, 0, 0);
            if (k == 15) begin
                checkOutput("up16 count at 15", act_c[0], 15);
                checkOutput("up16 tc at 15", act_tc[0], 1);
            end
        end
        checkOutput("up16 count after 20", act_c[0], 4);
        checkOutput("up16 ovf after wrap", act_ov[0], 1);
        checkOutput("up10 count after 20", act_c[1], 0);
        checkOutput("sat10 count after 20", act_c[2], 9);
        checkOutput("up256 count after 20", act_c[3], 20);
        checkOutput("up256 ovf after 20", act_ov[3], 0);

        // Down count from reset
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 11; k++) begin
            applyStimulus(0, 1, 0, 0, 0, 0);
            if (k == 1) begin
                checkOutput("down10 first edge", act_c[1], 9);
                checkOutput("down10 ovf first edge", act_ov[1], 1);
                checkOutput("sat10 down hold at 0", act_c[2], 0);
                checkOutput("down256 first edge", act_c[3], 255);
            end
        end
        checkOutput("down10 after 11", act_c[1], 9);

        // Saturation
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 8, 0);
        checkOutput("load 8", act_c[2], 8);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 1, 1, 0, 0, 0);
            if (k == 1) checkOutput("sat ovf before boundary", act_ov[2], 0);
            if (k == 2) checkOutput("sat ovf at boundary", act_ov[2], 1);
        end
        checkOutput("sat hold at 9", act_c[2], 9);
        for (int k = 1; k <= 3; k++) applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("sat down to 6", act_c[2], 6);

        // Load clamp and priority
        applyStimulus(0, 0, 0, 1, 13, 0);
        checkOutput("load clamp mod10", act_c[1], 9);
        checkOutput("load 13 mod16", act_c[0], 13);
        applyStimulus(0, 1, 1, 1, 2, 0);
        checkOutput("load beats en", act_c[2], 2);
        checkOutput("load keeps ovf", act_ov[2], 1);
        applyStimulus(1, 1, 1, 1, 2, 0);
        checkOutput("rst beats load", act_c[3], 0);
        checkOutput("rst clears ovf", act_ov[2], 0);

        // Sticky flag versus clear
        applyStimulus(0, 0, 0, 1, 15, 0);
        applyStimulus(0, 1, 1, 0, 0, 1);
        checkOutput("wrap with clr count", act_c[0], 0);
        checkOutput("wrap with clr ovf", act_ov[0], 1);
        applyStimulus(0, 0, 1, 0, 0, 1);
        checkOutput("clr without wrap", act_ov[0], 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("hold", act_c[0], 0);

        // Full-range 8-bit wrap
        applyStimulus(0, 0, 0, 1, 250, 0);
        checkOutput("load 250", act_c[3], 250);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(0, 1, 1, 0, 0, 0);
            if (k == 5) begin
                checkOutput("w8 count 255", act_c[3], 255);
                checkOutput("w8 tc at 255", act_tc[3], 1);
            end
            if (k == 6) checkOutput("w8 wrap ovf", act_ov[3], 1);
        end
        checkOutput("w8 count after 10", act_c[3], 4);

        @(negedge clk);
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
